// File: rtl/mc_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, PC select codes
// and the cp0 cause codes it reports.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_NPC = 2'b00;  // datapath next-PC (incl. eret)
  localparam logic [1:0] PC_SEL_EXC = 2'b10;  // exception vector

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_BUS = 5'd7;

endpackage

// File: rtl/mc_seq_if.sv
// Sequencer <-> datapath/memory bundle. The sequencer side (master) consumes
// decode flags and memory ready lines and drives every strobe.
interface mc_seq_if;
  logic       is_load;
  logic       is_store;
  logic       has_wb;
  logic       is_eret;
  logic       irq;
  logic       im_ready;
  logic       dm_ready;
  logic       im_req;
  logic       ir_w;
  logic       dm_req;
  logic       dm_we;
  logic       reg_we;
  logic       pc_w;
  logic [1:0] pc_sel;
  logic       cp0_epc;
  logic [4:0] exc_code;
  logic [2:0] state;

  modport master (
    input  is_load, is_store, has_wb, is_eret, irq, im_ready, dm_ready,
    output im_req, ir_w, dm_req, dm_we, reg_we, pc_w, pc_sel, cp0_epc,
           exc_code, state
  );

  modport slave (
    output is_load, is_store, has_wb, is_eret, irq, im_ready, dm_ready,
    input  im_req, ir_w, dm_req, dm_we, reg_we, pc_w, pc_sel, cp0_epc,
           exc_code, state
  );
endinterface

// File: rtl/mc_seq_wdog.sv
// Memory wait watchdog: clearable counter that saturates at MEM_TIMEOUT and
// flags expiry once it sits there.
module mc_seq_wdog #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; hold at LIMIT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (inc_i && cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mc_seq.sv
// Multi-cycle MIPS sequencer: walks each instruction through IF/ID/EX/MEM/WB,
// waits on variable-latency memories and raises interrupt / bus-error entries
// into cp0. A memory phase waits MEM_TIMEOUT cycles with ready low and then
// gets one final cycle (counter == MEM_TIMEOUT) in which ready still wins.
module mc_seq
  import mc_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic      clk,
  input  logic      reset,
  mc_seq_if.master  bus
);

  state_e     state_q, state_d;
  logic       im_req_q, dm_req_q, dm_we_q, cp0_epc_q;
  logic [1:0] pc_sel_q;
  logic [4:0] exc_code_q;

  logic fetching, expired, timeout, cnt_clr, cnt_inc;

  // im_req is low in the first cycle after reset, so fetch handshakes only
  // count once the request is actually on the bus.
  assign fetching = (state_q == S_IF) && im_req_q;

  // Next-state decision; timeout marks a bus-error exception entry.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_IF: begin
        if (fetching) begin
          if (bus.im_ready) state_d = S_ID;
          else if (expired) begin
            state_d = S_EXC;
            timeout = 1'b1;
          end
        end
      end
      S_ID:  state_d = S_EX;
      S_EX:  state_d = (bus.is_load || bus.is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dm_ready) state_d = S_WB;
        else if (expired) begin
          state_d = S_EXC;
          timeout = 1'b1;
        end
      end
      S_WB:    state_d = (bus.irq && !bus.is_eret) ? S_EXC : S_IF;
      S_EXC:   state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  assign cnt_clr = (state_d != state_q);
  assign cnt_inc = (fetching && !bus.im_ready) ||
                   ((state_q == S_MEM) && !bus.dm_ready);

  mc_seq_wdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .expired_o (expired)
  );

  // State register plus Moore outputs registered from the next state, so a
  // reset drops dm_req/dm_we on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      im_req_q   <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      cp0_epc_q  <= 1'b0;
      pc_sel_q   <= PC_SEL_NPC;
      exc_code_q <= EXC_INT;
    end else begin
      state_q   <= state_d;
      im_req_q  <= (state_d == S_IF);
      dm_req_q  <= (state_d == S_MEM);
      // Write enable captured on MEM entry and held for the whole access.
      if (state_d == S_MEM) dm_we_q <= (state_q == S_MEM) ? dm_we_q : bus.is_store;
      else                  dm_we_q <= 1'b0;
      cp0_epc_q <= (state_d == S_EXC);
      pc_sel_q  <= (state_d == S_EXC) ? PC_SEL_EXC : PC_SEL_NPC;
      if (state_d == S_EXC) exc_code_q <= timeout ? EXC_BUS : EXC_INT;
      else                  exc_code_q <= EXC_INT;
    end
  end

  assign bus.im_req   = im_req_q;
  assign bus.dm_req   = dm_req_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.cp0_epc  = cp0_epc_q;
  assign bus.pc_sel   = pc_sel_q;
  assign bus.exc_code = exc_code_q;
  assign bus.state    = state_q;

  // Handshake-qualified pulses.
  assign bus.ir_w   = fetching && bus.im_ready;
  assign bus.reg_we = (state_q == S_WB) && bus.has_wb && !bus.is_store;
  assign bus.pc_w   = (state_q == S_WB) || (state_q == S_EXC);

endmodule
